// File: rtl/wrf_arb_pkg.sv
// Shared types and constants for the two-source WR fabric arbiter.
// Holds the FSM state enum, fabric address codes and mux bundles.
package wrf_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DRAIN
    } t_wrf_arb_state;

    localparam logic [1:0] c_WRF_DATA   = 2'b00;
    localparam logic [1:0] c_WRF_OOB    = 2'b01;
    localparam logic [1:0] c_WRF_STATUS = 2'b10;
    localparam logic [1:0] c_WRF_USER   = 2'b11;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [1:0]  adr;
        logic [15:0] dat;
        logic [1:0]  sel;
    } t_wrf_source_out;

    typedef struct packed {
        logic ack;
        logic stall;
        logic err;
    } t_wrf_sink_out;

    // Response seen by any source that does not own the sink.
    localparam t_wrf_sink_out c_SINK_HOLD = '{
        ack:   1'b0,
        stall: 1'b1,
        err:   1'b0
    };

    // One-hot winner. last1 = port 1 held the previous grant.
    function automatic logic [1:0] f_pick(
        input logic cyc0,
        input logic cyc1,
        input logic last1,
        input logic fixed
    );
        logic [1:0] g;
        g = 2'b00;
        unique case (1'b1)
            (cyc0 && cyc1): g = (fixed || last1) ? 2'b01 : 2'b10;
            (cyc0 && !cyc1): g = 2'b01;
            (!cyc0 && cyc1): g = 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/wrf_src_arbiter_if.sv
// Pipelined Wishbone WR fabric link: 16-bit data, 2-bit address.
// master drives cyc/stb/we/adr/dat/sel; slave returns ack/stall/err.
interface wrf_src_arbiter_if;

    logic        cyc;
    logic        stb;
    logic        we;
    logic [1:0]  adr;
    logic [15:0] dat;
    logic [1:0]  sel;
    logic        ack;
    logic        stall;
    logic        err;

    modport master (
        output cyc, stb, we, adr, dat, sel,
        input  ack, stall, err
    );

    modport slave (
        input  cyc, stb, we, adr, dat, sel,
        output ack, stall, err
    );

endinterface

// File: rtl/wrf_arb_outstanding_cnt.sv
// Saturating up/down count of accepted-but-unacked words.
// Ports: clk/rst_n, inc_i/dec_i; cnt_o, full_o, empty_o, empty_nxt_o.
module wrf_arb_outstanding_cnt #(
    parameter int G_MAX = 16,
    parameter int CW    = $clog2(G_MAX + 1)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [CW-1:0] cnt_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          empty_nxt_o
);

    localparam logic [CW-1:0] c_MAX = CW'(G_MAX);
    localparam logic [CW-1:0] c_ONE = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clamped at both ends; inc and dec together cancel.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && cnt_q != c_MAX) begin
            cnt_d = cnt_q + c_ONE;
        end else if (dec_i && !inc_i && cnt_q != '0) begin
            cnt_d = cnt_q - c_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o       = cnt_q;
    assign full_o      = (cnt_q == c_MAX);
    assign empty_o     = (cnt_q == '0);
    assign empty_nxt_o = (cnt_d == '0);

endmodule

// File: rtl/wrf_src_arbiter.sv
// Frame-granular two-source arbiter onto one WR fabric sink.
// Ports: clk_sys_i, rst_n_i, snk0/snk1 (slave), src (master), grant_o, busy_o.
module wrf_src_arbiter
    import wrf_arb_pkg::*;
#(
    parameter int g_priority_mode   = 0,
    parameter int g_max_outstanding = 16
) (
    input  logic              clk_sys_i,
    input  logic              rst_n_i,
    wrf_src_arbiter_if.slave  snk0,
    wrf_src_arbiter_if.slave  snk1,
    wrf_src_arbiter_if.master src,
    output logic [1:0]        grant_o,
    output logic              busy_o
);

    localparam int CW = $clog2(g_max_outstanding + 1);

    t_wrf_arb_state  state_q, state_d;
    logic [1:0]      grant_q, grant_d;
    logic            last_q, last_d;

    t_wrf_source_out req0, req1, req;
    t_wrf_sink_out   rsp, rsp0, rsp1;

    logic [CW-1:0]   cnt;
    logic            cnt_full;
    logic            cnt_empty;
    logic            cnt_empty_nxt;
    logic            in_busy;
    logic            in_drain;
    logic            src_stb;
    logic            xfer;
    logic            resp;

    assign req0 = '{cyc: snk0.cyc, stb: snk0.stb, we: snk0.we,
                    adr: snk0.adr, dat: snk0.dat, sel: snk0.sel};
    assign req1 = '{cyc: snk1.cyc, stb: snk1.stb, we: snk1.we,
                    adr: snk1.adr, dat: snk1.dat, sel: snk1.sel};

    always_comb begin
        req = '0;
        unique case (1'b1)
            grant_q[0]: req = req0;
            grant_q[1]: req = req1;
            default:    req = '0;
        endcase
    end

    assign in_busy  = (state_q == BUSY);
    assign in_drain = (state_q == DRAIN);

    // cyc stays up while acks are owed, even on the cycle the source
    // drops it, so the sink never sees a gap inside one frame.
    assign src_stb = in_busy & req.cyc & req.stb & ~cnt_full;
    assign src.cyc = in_drain | (in_busy & (req.cyc | ~cnt_empty));
    assign src.stb = src_stb;
    assign src.we  = req.we;
    assign src.adr = req.adr;
    assign src.dat = req.dat;
    assign src.sel = req.sel;

    assign xfer = src_stb & ~src.stall;
    assign resp = src.ack | src.err;

    // Responses only reach the owner while BUSY; in DRAIN they are
    // absorbed so a re-raised cyc cannot pick up stale acks.
    always_comb begin
        rsp = c_SINK_HOLD;
        if (in_busy) begin
            rsp.ack   = src.ack;
            rsp.stall = src.stall | cnt_full;
            rsp.err   = src.err;
        end
    end

    assign rsp0 = grant_q[0] ? rsp : c_SINK_HOLD;
    assign rsp1 = grant_q[1] ? rsp : c_SINK_HOLD;

    assign snk0.ack   = rsp0.ack;
    assign snk0.stall = rsp0.stall;
    assign snk0.err   = rsp0.err;
    assign snk1.ack   = rsp1.ack;
    assign snk1.stall = rsp1.stall;
    assign snk1.err   = rsp1.err;

    wrf_arb_outstanding_cnt #(
        .G_MAX (g_max_outstanding),
        .CW    (CW)
    ) u_cnt (
        .clk_i       (clk_sys_i),
        .rst_n_i     (rst_n_i),
        .inc_i       (xfer),
        .dec_i       (resp),
        .cnt_o       (cnt),
        .full_o      (cnt_full),
        .empty_o     (cnt_empty),
        .empty_nxt_o (cnt_empty_nxt)
    );

    // Release decisions use the count after this cycle's ack, so the
    // grant drops on the edge that retires the last word.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (snk0.cyc || snk1.cyc) begin
                    state_d = BUSY;
                    grant_d = f_pick(snk0.cyc, snk1.cyc, last_q,
                                     g_priority_mode != 0);
                end
            end
            BUSY: begin
                if (!req.cyc) begin
                    state_d = cnt_empty_nxt ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (cnt_empty_nxt) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && state_d == IDLE) begin
            grant_d = 2'b00;
            last_d  = grant_q[1];
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q != IDLE);

    logic unused_cnt;
    assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_wrf_src_arbiter.sv
// Directed bench for wrf_src_arbiter: round-robin/16 and fixed/4 copies
// share one stimulus; each step checks only the copy it targets.
module tb_wrf_src_arbiter;
    import wrf_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        s0_cyc, s0_stb, s0_we;
    logic [1:0]  s0_adr, s0_sel;
    logic [15:0] s0_dat;
    logic        s1_cyc, s1_stb, s1_we;
    logic [1:0]  s1_adr, s1_sel;
    logic [15:0] s1_dat;
    logic        k_ack, k_stall, k_err;

    logic [1:0]  ga, gb;
    logic        ba, bb;

    int nvec = 0;
    int nerr = 0;
    logic [15:0] w [10];

    wrf_src_arbiter_if ia0 ();
    wrf_src_arbiter_if ia1 ();
    wrf_src_arbiter_if ias ();
    wrf_src_arbiter_if ib0 ();
    wrf_src_arbiter_if ib1 ();
    wrf_src_arbiter_if ibs ();

    assign ia0.cyc = s0_cyc;  assign ib0.cyc = s0_cyc;
    assign ia0.stb = s0_stb;  assign ib0.stb = s0_stb;
    assign ia0.we  = s0_we;   assign ib0.we  = s0_we;
    assign ia0.adr = s0_adr;  assign ib0.adr = s0_adr;
    assign ia0.dat = s0_dat;  assign ib0.dat = s0_dat;
    assign ia0.sel = s0_sel;  assign ib0.sel = s0_sel;
    assign ia1.cyc = s1_cyc;  assign ib1.cyc = s1_cyc;
    assign ia1.stb = s1_stb;  assign ib1.stb = s1_stb;
    assign ia1.we  = s1_we;   assign ib1.we  = s1_we;
    assign ia1.adr = s1_adr;  assign ib1.adr = s1_adr;
    assign ia1.dat = s1_dat;  assign ib1.dat = s1_dat;
    assign ia1.sel = s1_sel;  assign ib1.sel = s1_sel;
    assign ias.ack   = k_ack;   assign ibs.ack   = k_ack;
    assign ias.stall = k_stall; assign ibs.stall = k_stall;
    assign ias.err   = k_err;   assign ibs.err   = k_err;

    wrf_src_arbiter #(
        .g_priority_mode   (0),
        .g_max_outstanding (16)
    ) dut_a (
        .clk_sys_i (clk),
        .rst_n_i   (rst_n),
        .snk0      (ia0),
        .snk1      (ia1),
        .src       (ias),
        .grant_o   (ga),
        .busy_o    (ba)
    );

    wrf_src_arbiter #(
        .g_priority_mode   (1),
        .g_max_outstanding (4)
    ) dut_b (
        .clk_sys_i (clk),
        .rst_n_i   (rst_n),
        .snk0      (ib0),
        .snk1      (ib1),
        .src       (ibs),
        .grant_o   (gb),
        .busy_o    (bb)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_drv();
        s0_cyc = 0; s0_stb = 0; s0_we = 0;
        s0_adr = 0; s0_sel = 0; s0_dat = 0;
        s1_cyc = 0; s1_stb = 0; s1_we = 0;
        s1_adr = 0; s1_sel = 0; s1_dat = 0;
        k_ack = 0; k_stall = 0; k_err = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_drv();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int  seen;
        int  j;
        logic adv;
        logic done;

        idle_drv();
        for (int i = 0; i < 10; i++) w[i] = 16'hA500 + 16'(i * 3 + 1);

        // reset values hold even with live inputs
        s0_cyc = 1; s0_we = 1; s0_dat = 16'hFFFF; s0_sel = 2'b11;
        k_ack = 1; k_err = 1;
        #12;
        chk("rst_gnt", ga, 2'b00);
        chk("rst_busy", ba, 0);
        chk("rst_cyc", ias.cyc, 0);
        chk("rst_stb", ias.stb, 0);
        chk("rst_we", ias.we, 0);
        chk("rst_dat", ias.dat, 0);
        chk("rst_sel", ias.sel, 0);
        chk("rst_ack0", ia0.ack, 0);
        chk("rst_err0", ia0.err, 0);
        chk("rst_stall0", ia0.stall, 1);
        chk("rst_stall1", ia1.stall, 1);
        do_reset();

        // T1: 8-word frame on port 0, ack one cycle later
        s0_cyc = 1; s0_stb = 1; s0_we = 1;
        s0_sel = 2'b11; s0_adr = c_WRF_DATA; s0_dat = w[0];
        #1;
        chk("t1_lat_cyc", ias.cyc, 0);
        chk("t1_lat_stall", ia0.stall, 1);
        for (int i = 0; i < 9; i++) begin
            nxt();
            s0_cyc = (i < 8);
            s0_stb = (i < 8);
            if (i < 8) s0_dat = w[i];
            k_ack = (i >= 1);
            #1;
            chk("t1_gnt", ga, 2'b01);
            chk("t1_cyc", ias.cyc, 1);
            chk("t1_stb", ias.stb, 32'(i < 8));
            if (i < 8) chk("t1_dat", ias.dat, w[i]);
            chk("t1_ack0", ia0.ack, 32'(i >= 1));
            chk("t1_stall1", ia1.stall, 1);
        end
        nxt();
        k_ack = 0;
        #1;
        chk("t1_end_gnt", ga, 2'b00);
        chk("t1_end_busy", ba, 0);
        chk("t1_end_cyc", ias.cyc, 0);
        do_reset();

        // T2: simultaneous requests, round-robin
        s0_cyc = 1; s1_cyc = 1; s0_stb = 1; s1_stb = 1;
        s0_dat = 16'h1111; s1_dat = 16'h2222;
        nxt(); #1;
        chk("t2_gnt0", ga, 2'b01);
        chk("t2_dat0", ias.dat, 16'h1111);
        chk("t2_stall1", ia1.stall, 1);
        nxt(); s0_stb = 0; k_ack = 1; #1;
        chk("t2_ack0", ia0.ack, 1);
        chk("t2_ack1", ia1.ack, 0);
        nxt(); s0_cyc = 0; k_ack = 0; #1;
        chk("t2_hold", ga, 2'b01);
        nxt(); #1;
        chk("t2_gap_gnt", ga, 2'b00);
        chk("t2_gap_cyc", ias.cyc, 0);
        nxt(); #1;
        chk("t2_gnt1", ga, 2'b10);
        chk("t2_dat1", ias.dat, 16'h2222);
        chk("t2_stall0", ia0.stall, 1);
        nxt(); s1_stb = 0; k_err = 1; #1;
        chk("t2_err1", ia1.err, 1);
        chk("t2_err0", ia0.err, 0);
        nxt(); k_err = 0; #1;
        chk("t2_noabort", ga, 2'b10);
        nxt(); s1_cyc = 0; #1;
        nxt(); s0_cyc = 1; s1_cyc = 1; #1;
        chk("t2_idle", ga, 2'b00);
        nxt(); #1;
        chk("t2_rr_back", ga, 2'b01);
        do_reset();

        // T3: fixed priority, both requesting
        s0_cyc = 1; s1_cyc = 1;
        #1;
        chk("t3_start", gb, 2'b00);
        for (int f = 0; f < 3; f++) begin
            nxt(); s0_cyc = 0; #1;
            chk("t3_fp0", gb, 2'b01);
            nxt(); if (f < 2) s0_cyc = 1; #1;
            chk("t3_gap", gb, 2'b00);
        end
        nxt(); #1;
        chk("t3_p1", gb, 2'b10);
        do_reset();

        // T4: limit 4, sink silent, then acks released
        seen = 0; j = 0; adv = 0; done = 0;
        s0_cyc = 1; s0_stb = 1; s0_dat = w[0];
        for (int c = 0; c < 9; c++) begin
            nxt();
            if (adv) begin j++; s0_dat = w[j]; end
            #1;
            if (ibs.stb && !k_stall) begin
                if (seen < 10) chk("t4_dat", ibs.dat, w[seen]);
                seen++;
            end
            adv = !ib0.stall;
        end
        chk("t4_accepted", seen, 4);
        chk("t4_stall", ib0.stall, 1);
        chk("t4_stb_mask", ibs.stb, 0);
        for (int c = 0; c < 40 && !done; c++) begin
            nxt();
            k_ack = 1;
            if (adv) begin
                j++;
                if (j < 10) s0_dat = w[j];
                else begin s0_stb = 0; s0_cyc = 0; end
            end
            #1;
            if (ibs.stb && !k_stall) begin
                if (seen < 10) chk("t4_dat", ibs.dat, w[seen]);
                seen++;
            end
            adv = !ib0.stall && s0_stb;
            if (j >= 10 && !bb) done = 1;
        end
        chk("t4_done", done, 1);
        chk("t4_total", seen, 10);
        chk("t4_cyc_low", ibs.cyc, 0);
        do_reset();

        // T5: cyc drops with 3 words owed
        s0_cyc = 1; s0_stb = 1; s0_dat = w[0];
        for (int i = 0; i < 3; i++) begin
            nxt(); s0_dat = w[i]; #1;
            chk("t5_dat", ias.dat, w[i]);
        end
        nxt(); s0_cyc = 0; s0_stb = 0; #1;
        chk("t5_hold_cyc", ias.cyc, 1);
        chk("t5_hold_stb", ias.stb, 0);
        for (int k = 0; k < 3; k++) begin
            nxt(); k_ack = 1; s0_cyc = 1; s0_stb = 1; #1;
            chk("t5_state", dut_a.state_q, DRAIN);
            chk("t5_cyc", ias.cyc, 1);
            chk("t5_stb", ias.stb, 0);
            chk("t5_ack0", ia0.ack, 0);
            chk("t5_stall0", ia0.stall, 1);
        end
        nxt(); k_ack = 0; #1;
        chk("t5_idle_busy", ba, 0);
        chk("t5_idle_cyc", ias.cyc, 0);
        chk("t5_idle_gnt", ga, 2'b00);
        nxt(); k_stall = 1; #1;
        chk("t5_regrant", ga, 2'b01);
        chk("t5_stall_fwd", ia0.stall, 1);
        do_reset();

        // T6: async reset mid-frame with 5 owed
        s0_cyc = 1; s0_stb = 1; s0_we = 1;
        s0_sel = 2'b11; s0_adr = c_WRF_OOB;
        for (int i = 0; i < 5; i++) begin
            nxt(); s0_dat = w[i]; #1;
        end
        nxt(); s0_stb = 0; #1;
        chk("t6_cnt5", dut_a.u_cnt.cnt_q, 5);
        k_ack = 1; k_err = 1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_gnt", ga, 2'b00);
        chk("t6_busy", ba, 0);
        chk("t6_cyc", ias.cyc, 0);
        chk("t6_we", ias.we, 0);
        chk("t6_adr", ias.adr, 0);
        chk("t6_dat", ias.dat, 0);
        chk("t6_ack0", ia0.ack, 0);
        chk("t6_err0", ia0.err, 0);
        chk("t6_stall0", ia0.stall, 1);
        chk("t6_cnt0", dut_a.u_cnt.cnt_q, 0);
        idle_drv();
        #3;
        rst_n = 1'b1;
        s1_cyc = 1; s1_stb = 1; s1_dat = 16'h5A5A;
        #1;
        chk("t6_pre", ga, 2'b00);
        nxt(); #1;
        chk("t6_gnt1", ga, 2'b10);
        chk("t6_cnt_start", dut_a.u_cnt.cnt_q, 0);
        chk("t6_dat1", ias.dat, 16'h5A5A);
        chk("t6_stb1", ias.stb, 1);
        nxt(); s1_stb = 0; k_ack = 1; #1;
        chk("t6_ack1", ia1.ack, 1);
        nxt(); s1_cyc = 0; k_ack = 0; #1;
        nxt(); #1;
        chk("t6_end", ba, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
